// File: rtl/mem_port_arbiter_if.sv
// Bundle between N requesting masters, the arbiter and the single memory port.
// slave = arbiter side; master = the masters-plus-memory environment side.
interface mem_port_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16
);
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0]            m_read_en;
  logic [NUM_MASTERS-1:0]            m_write_en;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0]             m_rdata;
  logic [NUM_MASTERS-1:0]            m_ready;
  logic [NUM_MASTERS-1:0]            m_error;
  logic [ADDR_WIDTH-1:0]             mem_addr_out;
  logic [DATA_WIDTH-1:0]             mem_data_out;
  logic                              mem_read_en;
  logic                              mem_write_en;
  logic [DATA_WIDTH-1:0]             mem_data_in;
  logic                              mem_ready;
  logic [GW-1:0]                     grant_id;
  logic                              busy;

  modport slave (
    input  m_read_en, m_write_en, m_addr, m_wdata, mem_data_in, mem_ready,
    output m_rdata, m_ready, m_error, mem_addr_out, mem_data_out,
           mem_read_en, mem_write_en, grant_id, busy
  );

  modport master (
    output m_read_en, m_write_en, m_addr, m_wdata, mem_data_in, mem_ready,
    input  m_rdata, m_ready, m_error, mem_addr_out, mem_data_out,
           mem_read_en, mem_write_en, grant_id, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-master arbiter onto one memory port, one transaction in flight, fixed or round-robin.
// Grant registered at the request edge; masters hold requests until their one-cycle m_ready pulse.
module mem_port_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int ARB_MODE       = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset_n,
  mem_port_arbiter_if.slave bus
);
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdat_q, wdat_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [NUM_MASTERS-1:0] ready_q, ready_d;
  logic [NUM_MASTERS-1:0] error_q, error_d;
  logic [CW-1:0]          wcnt_q, wcnt_d;

  logic [NUM_MASTERS-1:0] req;
  logic [GW-1:0]          win;
  int                     arb_idx;

  // Scan in reverse priority order so the highest-priority requester is assigned last.
  always_comb begin
    req     = bus.m_read_en | bus.m_write_en;
    win     = '0;
    arb_idx = 0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req[i]) win = GW'(i);
      end
    end else begin
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        arb_idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
        if (req[arb_idx]) win = GW'(arb_idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    rdata_d  = rdata_q;
    ready_d  = '0;
    error_d  = '0;
    wcnt_d   = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d  = win;
          rr_ptr_d = win;
          addr_d   = bus.m_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
          wr_d     = bus.m_write_en[win];
          rd_d     = !bus.m_write_en[win];
          wdat_d   = bus.m_write_en[win] ? bus.m_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH] : '0;
          wcnt_d   = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_ready) begin
          rd_d             = 1'b0;
          wr_d             = 1'b0;
          rdata_d          = rd_q ? bus.mem_data_in : '0;
          ready_d[grant_q] = 1'b1;
          state_d          = S_RESP;
        end else if (TIMEOUT_CYCLES != 0 && wcnt_q == TO_LAST) begin
          rd_d             = 1'b0;
          wr_d             = 1'b0;
          rdata_d          = '0;
          ready_d[grant_q] = 1'b1;
          error_d[grant_q] = 1'b1;
          state_d          = S_RESP;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= GW'(NUM_MASTERS - 1);
      grant_q  <= '0;
      addr_q   <= '0;
      wdat_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      ready_q  <= '0;
      error_q  <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign bus.m_rdata      = rdata_q;
  assign bus.m_ready      = ready_q;
  assign bus.m_error      = error_q;
  assign bus.mem_addr_out = addr_q;
  assign bus.mem_data_out = wdat_q;
  assign bus.mem_read_en  = rd_q;
  assign bus.mem_write_en = wr_q;
  assign bus.grant_id     = grant_q;
  assign bus.busy         = (state_q != S_IDLE);
endmodule
